// File: rtl/serial_adder_ctrl_if.sv
// Handshake and operand/result bundle for serial_adder_ctrl.
// The master side issues operations; the slave side is the controller.
interface serial_adder_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic         op_sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         zero;

    modport master (
        output start, op_sub, cin, a, b,
        input  busy, done, sum, cout, zero
    );

    modport slave (
        input  start, op_sub, cin, a, b,
        output busy, done, sum, cout, zero
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Nibble-serial adder/subtractor: one shared 4-bit adder processes the
// operands LSB nibble first, one nibble per cycle, rippling the carry
// through a register. Subtraction is a + ~b + 1.

// Shared 4-bit ripple building block.
module fourbit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    serial_adder_ctrl_if.slave bus
);
    localparam int DATA_W = 4 * NIBBLES;
    localparam int IDX_W  = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                capture;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   sum_q;
    logic [DATA_W-1:0]   sum_nxt;
    logic [IDX_W-1:0]    idx_q;
    logic                carry_q;
    logic                cout_q;
    logic                zero_q;
    logic [3:0]          a_nib;
    logic [3:0]          b_nib;
    logic [3:0]          add_sum;
    logic                add_cout;

    assign a_nib = a_q[4*idx_q +: 4];
    assign b_nib = b_q[4*idx_q +: 4];

    fourbit_adder u_add (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and capture strobe; start is only honoured in IDLE or DONE.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    capture = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (idx_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    capture = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result register with the current nibble spliced in.
    always_comb begin
        sum_nxt = sum_q;
        sum_nxt[4*idx_q +: 4] = add_sum;
    end

    // Operand capture; subtraction stores the inverted B operand.
    always_ff @(posedge clk) begin
        if (capture) begin
            a_q <= bus.a;
            b_q <= bus.op_sub ? ~bus.b : bus.b;
        end
    end

    // Carry, nibble index and result flags; flags change only at completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b1;
        end else if (state_q == RUN) begin
            sum_q   <= sum_nxt;
            carry_q <= add_cout;
            idx_q   <= idx_q + 1'b1;
            if (idx_q == LAST) begin
                idx_q  <= '0;
                cout_q <= add_cout;
                zero_q <= (sum_nxt == '0);
            end
        end else if (capture) begin
            carry_q <= bus.op_sub ? 1'b1 : bus.cin;
            idx_q   <= '0;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.zero = zero_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl with NIBBLES=4.
module tb_serial_adder_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         zero;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    res_t sb[$];

    serial_adder_ctrl_if #(.NIBBLES(N)) dut_if ();

    serial_adder_ctrl #(.NIBBLES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if)
    );

    always #5 clk = ~clk;

    function automatic res_t model(bit sub, bit ci, logic [W-1:0] x, logic [W-1:0] y);
        res_t r;
        logic [W:0] full;
        if (sub) begin
            r.sum  = x - y;
            r.cout = (x >= y);
        end else begin
            full   = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
            r.sum  = full[W-1:0];
            r.cout = full[W];
        end
        r.zero = (r.sum == '0);
        return r;
    endfunction

    function automatic res_t observed();
        res_t r;
        r.sum  = dut_if.sum;
        r.cout = dut_if.cout;
        r.zero = dut_if.zero;
        return r;
    endfunction

    // Called at a negedge: drive one request, push its expectation, pass the edge.
    task automatic launch(bit sub, bit ci, logic [W-1:0] x, logic [W-1:0] y, bit hold);
        dut_if.start  = 1'b1;
        dut_if.op_sub = sub;
        dut_if.cin    = ci;
        dut_if.a      = x;
        dut_if.b      = y;
        sb.push_back(model(sub, ci, x, y));
        @(posedge clk);
        #1;
        if (!hold) dut_if.start = 1'b0;
    endtask

    // Wait (bounded) for done; counts negedges seen with busy high beforehand.
    task automatic wait_done(output int cyc, output bit seen);
        cyc  = 0;
        seen = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (dut_if.done) begin
                seen = 1'b1;
                break;
            end
            if (dut_if.busy) cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dut_if.start = 1'b0; dut_if.op_sub = 1'b0; dut_if.cin = 1'b0;
        dut_if.a = '0; dut_if.b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({dut_if.busy, dut_if.done, observed()} !== {2'b00, res_t'({16'h0000, 1'b0, 1'b1})}) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b res=%h required busy=0 done=0 sum=0 cout=0 zero=1",
                     dut_if.busy, dut_if.done, observed());
        end
        rst = 1'b0;
    endtask

    task automatic test_add_basic();
        int cyc; bit seen; res_t e;
        @(negedge clk);
        launch(1'b0, 1'b0, 16'h1234, 16'h0FFF, 1'b0);
        wait_done(cyc, seen);
        checks++;
        if (!seen || cyc !== N) begin
            errors++;
            $display("FAIL add_basic_latency: got seen=%0b busy_cycles=%0d required seen=1 busy_cycles=%0d", seen, cyc, N);
        end
        e = sb.pop_front();
        checks++;
        if (observed() !== e || e.sum !== 16'h2233) begin
            errors++;
            $display("FAIL add_basic_result: got %h required %h (sum 2233)", observed(), e);
        end
        @(negedge clk);
        checks++;
        if ({dut_if.busy, dut_if.done} !== 2'b00 || observed() !== e) begin
            errors++;
            $display("FAIL done_pulse_hold: got busy=%b done=%b res=%h required busy=0 done=0 res=%h",
                     dut_if.busy, dut_if.done, observed(), e);
        end
    endtask

    task automatic test_add_ripple();
        int cyc; bit seen; res_t e;
        @(negedge clk);
        launch(1'b0, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
        @(negedge clk);
        checks++;
        if ({dut_if.busy, dut_if.cout, dut_if.zero} !== 3'b100) begin
            errors++;
            $display("FAIL flags_held_in_run: got busy=%b cout=%b zero=%b required busy=1 cout=0 zero=0",
                     dut_if.busy, dut_if.cout, dut_if.zero);
        end
        wait_done(cyc, seen);
        checks++;
        if (!seen || cyc !== N - 1) begin
            errors++;
            $display("FAIL ripple_latency: got seen=%0b busy_cycles=%0d required seen=1 busy_cycles=%0d", seen, cyc + 1, N);
        end
        e = sb.pop_front();
        checks++;
        if (observed() !== e || observed() !== res_t'({16'h0000, 1'b1, 1'b1})) begin
            errors++;
            $display("FAIL ripple_result: got %h required %h", observed(), e);
        end
    endtask

    task automatic test_sub();
        int cyc; bit seen; res_t e;
        @(negedge clk);
        launch(1'b1, 1'b1, 16'h0005, 16'h0007, 1'b0);
        wait_done(cyc, seen);
        checks++;
        if (!seen || cyc !== N) begin
            errors++;
            $display("FAIL sub_latency: got seen=%0b busy_cycles=%0d required seen=1 busy_cycles=%0d", seen, cyc, N);
        end
        e = sb.pop_front();
        checks++;
        if (observed() !== e || observed() !== res_t'({16'hFFFE, 1'b0, 1'b0})) begin
            errors++;
            $display("FAIL sub_result: got %h required %h", observed(), e);
        end
    endtask

    task automatic test_start_in_run();
        int cyc; bit seen; res_t e;
        @(negedge clk);
        launch(1'b0, 1'b1, 16'h1111, 16'h2222, 1'b0);
        @(negedge clk);
        @(negedge clk);
        dut_if.start = 1'b1; dut_if.op_sub = 1'b1;
        dut_if.a = 16'hABCD; dut_if.b = 16'h5A5A;
        @(posedge clk);
        #1 dut_if.start = 1'b0;
        wait_done(cyc, seen);
        checks++;
        if (!seen || cyc + 2 !== N) begin
            errors++;
            $display("FAIL run_start_latency: got seen=%0b busy_cycles=%0d required seen=1 busy_cycles=%0d", seen, cyc + 2, N);
        end
        e = sb.pop_front();
        checks++;
        if (observed() !== e) begin
            errors++;
            $display("FAIL run_start_ignored: got %h required %h", observed(), e);
        end
        @(negedge clk);
        checks++;
        if (dut_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL run_start_no_restart: got busy=%b required busy=0", dut_if.busy);
        end
    endtask

    task automatic test_reset_in_run();
        int cyc; bit seen; bit saw_done; res_t e;
        @(negedge clk);
        launch(1'b0, 1'b0, 16'h1234, 16'h4321, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        sb.delete();
        checks++;
        if ({dut_if.busy, dut_if.done, observed()} !== {2'b00, res_t'({16'h0000, 1'b0, 1'b1})}) begin
            errors++;
            $display("FAIL reset_abort: got busy=%b done=%b res=%h required busy=0 done=0 sum=0 cout=0 zero=1",
                     dut_if.busy, dut_if.done, observed());
        end
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (dut_if.done || dut_if.busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: got activity=%b required activity=0", saw_done);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        launch(1'b0, 1'b0, 16'h0001, 16'h0001, 1'b0);
        wait_done(cyc, seen);
        checks++;
        if (!seen || cyc !== N) begin
            errors++;
            $display("FAIL first_start_after_reset: got seen=%0b busy_cycles=%0d required seen=1 busy_cycles=%0d", seen, cyc, N);
        end
        e = sb.pop_front();
        checks++;
        if (observed() !== e || dut_if.sum !== 16'h0002) begin
            errors++;
            $display("FAIL post_reset_result: got %h required %h", observed(), e);
        end
    endtask

    task automatic test_back_to_back();
        int cyc; bit seen; res_t e;
        @(negedge clk);
        launch(1'b0, 1'b1, 16'h8000, 16'h8000, 1'b1);
        dut_if.op_sub = 1'b1; dut_if.cin = 1'b0;
        dut_if.a = 16'h0100; dut_if.b = 16'h0001;
        sb.push_back(model(1'b1, 1'b0, 16'h0100, 16'h0001));
        wait_done(cyc, seen);
        checks++;
        if (!seen || cyc !== N) begin
            errors++;
            $display("FAIL b2b_first_latency: got seen=%0b busy_cycles=%0d required seen=1 busy_cycles=%0d", seen, cyc, N);
        end
        e = sb.pop_front();
        checks++;
        if (observed() !== e) begin
            errors++;
            $display("FAIL b2b_first_result: got %h required %h", observed(), e);
        end
        @(posedge clk);
        #1 dut_if.start = 1'b0;
        @(negedge clk);
        checks++;
        if (dut_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_no_idle: got busy=%b required busy=1", dut_if.busy);
        end
        wait_done(cyc, seen);
        checks++;
        if (!seen || cyc + 1 !== N) begin
            errors++;
            $display("FAIL b2b_second_latency: got seen=%0b busy_cycles=%0d required seen=1 busy_cycles=%0d", seen, cyc + 1, N);
        end
        e = sb.pop_front();
        checks++;
        if (observed() !== e || dut_if.sum !== 16'h00FF) begin
            errors++;
            $display("FAIL b2b_second_result: got %h required %h", observed(), e);
        end
    endtask

    task automatic test_random();
        int cyc; bit seen; res_t e;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            launch(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   16'($urandom), 16'($urandom), 1'b0);
            wait_done(cyc, seen);
            e = sb.pop_front();
            checks++;
            if (!seen || cyc !== N || observed() !== e) begin
                errors++;
                $display("FAIL random_op%0d: got seen=%0b cycles=%0d res=%h required seen=1 cycles=%0d res=%h",
                         i, seen, cyc, observed(), N, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_add_ripple();
        test_sub();
        test_start_in_run();
        test_reset_in_run();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, giving the operand width as 4*NIBBLES bits (W) and the add duration in cycles; legal range 2..8.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to begin an operation; sampled on the rising edge.
REQ-005 SHALL have port op_sub, input, 1: 0 = add, 1 = subtract (a - b); sampled with start.
REQ-006 SHALL have port cin, input, 1, carry-in for add; ignored when op_sub=1.
REQ-007 SHALL have port a, input, W, first operand; sampled with start.
REQ-008 SHALL have port b, input, W, second operand; sampled with start.
REQ-009 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-010 SHALL have port done, output, 1, one-cycle pulse when the result is complete.
REQ-011 SHALL have port sum, output, W, result register.
REQ-012 SHALL have port cout, output, 1, final carry-out (for subtract, 1 = no borrow).
REQ-013 SHALL have port zero, output, 1, high when the completed sum equals 0.

Function
REQ-014 SHALL instantiate the team's fourbit_adder (a, b, cin, sum, cout) exactly once as the only adder; nibble arithmetic SHALL NOT be done with any other adder.
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 IDLE: start=1 -> capture a, b, op_sub and carry; set nibble index to 0; go to RUN. start=0 -> stay in IDLE.
REQ-017 On capture, the internal B operand SHALL be ~b when op_sub=1, otherwise b.
REQ-018 On capture, the carry register SHALL be loaded with 1 when op_sub=1, otherwise with cin.
REQ-019 Each RUN cycle: nibble k of A and B, plus the carry register, drive the fourbit_adder.
REQ-020 Each RUN cycle: the adder sum SHALL be written to sum[4k+3:4k] and the adder cout to the carry register, then k increments.
REQ-021 Nibble order SHALL be LSB first (k = 0 .. NIBBLES-1).
REQ-022 After the edge writing nibble NIBBLES-1 -> DONE; cout = final carry; zero = (sum == 0).
REQ-023 DONE SHALL last exactly one cycle with done=1; start=1 in DONE begins a new operation (back-to-back, as in IDLE), else -> IDLE.
REQ-024 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-025 Latency: start sampled at edge 0 -> busy high edges 0..NIBBLES -> done high between edges NIBBLES and NIBBLES+1.
REQ-026 start while in RUN SHALL be ignored; operands and progress unaffected.
REQ-027 sum, cout and zero SHALL hold the last completed result until the next operation; sum nibbles update progressively during RUN.
REQ-028 cout and zero SHALL NOT be updated during RUN.
REQ-029 Results are modulo 2^W; no overflow flag beyond cout.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, busy=0, done=0, sum=0, cout=0, zero=1, carry=0, index=0, regardless of clock.
REQ-031 Reset during RUN SHALL abort the operation; no done pulse SHALL follow.
REQ-032 The first start SHALL be honoured on the first rising edge after rst deasserts.

Verification
REQ-033 Bench SHALL cover, with NIBBLES=4: add a=0x1234, b=0x0FFF, cin=0 -> done 4 cycles after start; sum=0x2233, cout=0, zero=0.
REQ-034 Bench SHALL cover: add a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, zero=1; carry ripples across all 4 nibble cycles.
REQ-035 Bench SHALL cover: subtract op_sub=1, a=0x0005, b=0x0007 (cin=1 ignored) -> sum=0xFFFE, cout=0.
REQ-036 Bench SHALL cover: start pulsed with new operands in RUN cycle 2 -> ignored; original result delivered; busy stays high 4 cycles.
REQ-037 Bench SHALL cover: rst asserted in RUN cycle 2 -> busy=0, sum=0 at once, no done; then a=0x0001, b=0x0001 -> sum=0x0002.
REQ-038 Bench SHALL cover: start held high across DONE -> second operation begins the cycle after done with no IDLE cycle; both results correct.
